data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 136 +++++++++++++
 tb/tb_data_mem.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Data memory: DEPTH x 32-bit words, byte-addressed, with word/half/byte
// loads and stores, combinational reads and alignment/range error flags.
// Optional store trace is enabled by defining DATA_MEM_TRACE_EN.
module data_mem #(
    parameter int unsigned DEPTH = 3072,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [2:0]  MemOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [31:0] PC,
    output logic [31:0] RD,
    output logic        AdEL,
    output logic        AdES
);

    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_HS = 3'd1;
    localparam logic [2:0] OP_HU = 3'd2;
    localparam logic [2:0] OP_BS = 3'd3;
    localparam logic [2:0] OP_BU = 3'd4;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   offset;
    logic [IW-1:0] idx;
    logic          in_range;
    logic          misaligned;
    logic          commit;
    logic [31:0]   old_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [3:0]    wmask;
    logic [31:0]   wdata;
    logic [31:0]   merged;

    assign offset   = Addr - BASE;
    assign idx      = offset[IW+1:2];
    assign in_range = (offset < LIMIT);

    // Alignment check per access size; reserved ops count as misaligned
    always_comb begin
        misaligned = 1'b1;
        case (MemOp)
            OP_W:         misaligned = (offset[1:0] != 2'b00);
            OP_HS, OP_HU: misaligned = offset[0];
            OP_BS, OP_BU: misaligned = 1'b0;
            default:      misaligned = 1'b1;
        endcase
    end

    assign AdEL   = misaligned | ~in_range;
    assign AdES   = WE & AdEL;
    assign commit = WE & ~AdEL;

    // Addressed word; guarded so out-of-range indices never reach the array
    assign old_word = in_range ? mem[idx] : 32'h0;
    assign byte_sel = old_word[8*offset[1:0] +: 8];
    assign half_sel = offset[1] ? old_word[31:16] : old_word[15:0];

    // Load data extraction and extension; forced to zero on a load error
    always_comb begin
        RD = 32'h0;
        if (!AdEL) begin
            case (MemOp)
                OP_W:    RD = old_word;
                OP_HS:   RD = {{16{half_sel[15]}}, half_sel};
                OP_HU:   RD = {16'h0, half_sel};
                OP_BS:   RD = {{24{byte_sel[7]}}, byte_sel};
                OP_BU:   RD = {24'h0, byte_sel};
                default: RD = 32'h0;
            endcase
        end
    end

    // Lane mask and replicated store data; signed/unsigned store ops are equivalent
    always_comb begin
        wmask = 4'b0000;
        wdata = WD;
        case (MemOp)
            OP_W: begin
                wmask = 4'b1111;
                wdata = WD;
            end
            OP_HS, OP_HU: begin
                wmask = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WD[15:0]}};
            end
            OP_BS, OP_BU: begin
                wmask = 4'(1) << offset[1:0];
                wdata = {4{WD[7:0]}};
            end
            default: begin
                wmask = 4'b0000;
                wdata = WD;
            end
        endcase
    end

    // Merge new lanes into the current word contents
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    // Per-word storage with asynchronous clear
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_word
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem[g] <= 32'h0;
            end else if (commit && (idx == IW'(g))) begin
                mem[g] <= merged;
            end
        end
    end

`ifdef DATA_MEM_TRACE_EN
    // Trace each committed store with its merged word
    always_ff @(posedge clk) begin
        if (reset && commit) begin
            $display("@%08h: *%08h <= %08h", PC, {Addr[31:2], 2'b00}, merged);
        end
    end
`else
    logic trace_unused;
    assign trace_unused = ^PC;
`endif

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem using a byte-array reference model.
module tb_data_mem;

    localparam int unsigned DEPTH = 3072;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [2:0]  MemOp;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [31:0] PC;
    logic [31:0] RD;
    logic        AdEL;
    logic        AdES;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] mb [NBYTE];

    data_mem #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .WE    (WE),
        .MemOp (MemOp),
        .Addr  (Addr),
        .WD    (WD),
        .PC    (PC),
        .RD    (RD),
        .AdEL  (AdEL),
        .AdES  (AdES)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit ref_err(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= NBYTE) return 1'b1;
        if (op > 3'd4) return 1'b1;
        if (op == 3'd0 && (off % 4) != 0) return 1'b1;
        if ((op == 3'd1 || op == 3'd2) && (off % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [2:0] op, input logic [31:0] a);
        int unsigned off;
        logic [15:0] h;
        logic [7:0]  b;
        if (ref_err(op, a)) return 32'h0;
        off = int'(a - BASE);
        case (op)
            3'd0: return {mb[off+3], mb[off+2], mb[off+1], mb[off]};
            3'd1: begin h = {mb[off+1], mb[off]}; return {{16{h[15]}}, h}; end
            3'd2: begin h = {mb[off+1], mb[off]}; return {16'h0, h}; end
            3'd3: begin b = mb[off]; return {{24{b[7]}}, b}; end
            default: begin b = mb[off]; return {24'h0, b}; end
        endcase
    endfunction

    function automatic void ref_store(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] d);
        int unsigned off;
        int n;
        if (ref_err(op, a)) return;
        off = int'(a - BASE);
        n = (op == 3'd0) ? 4 : (op <= 3'd2) ? 2 : 1;
        for (int i = 0; i < n; i++) mb[off+i] = d[8*i +: 8];
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < int'(NBYTE); i++) mb[i] = 8'h0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic we, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d);
        WE = we; MemOp = op; Addr = a; WD = d; PC = $urandom();
    endtask

    // Store across one edge, updating the model as the spec says it commits
    task automatic do_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(1'b1, op, a, d);
        @(posedge clk);
        if (reset) ref_store(op, a, d);
        #1;
        WE = 1'b0;
    endtask

    // Apply a load between edges and settle
    task automatic do_load(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        drive(1'b0, op, a, 32'h0);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        compared++;
        if (RD !== 32'h0 || AdEL !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_load: RD=%h AdEL=%b want RD=0 AdEL=0", RD, AdEL);
        end
        drive(1'b1, 3'd0, 32'h31, 32'hFFFF_FFFF);
        #1;
        compared++;
        if (AdES !== 1'b1 || AdEL !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ades: AdES=%b AdEL=%b want 1 1", AdES, AdEL);
        end
        drive(1'b1, 3'd0, 32'h10, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        WE = 1'b0;
        #1;
        compared++;
        if (RD !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_store_ignored: RD=%h want 0", RD);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_word();
        do_store(3'd0, 32'h10, 32'h1234_5678);
        do_load(3'd0, 32'h10);
        compared++;
        if (RD !== 32'h1234_5678 || AdEL !== 1'b0) begin
            mismatched++;
            $display("FAIL word_rw: RD=%h AdEL=%b want 12345678 0", RD, AdEL);
        end
    endtask

    task automatic test_byte_merge();
        logic [31:0] want [3];
        logic [2:0]  ops [3];
        logic [31:0] adr [3];
        want = '{32'hAB34_5678, 32'hFFFF_FFAB, 32'h0000_00AB};
        ops  = '{3'd0, 3'd3, 3'd4};
        adr  = '{32'h10, 32'h13, 32'h13};
        do_store(3'd3, 32'h13, 32'h0000_00AB);
        for (int i = 0; i < 3; i++) begin
            do_load(ops[i], adr[i]);
            compared++;
            if (RD !== want[i] || RD !== ref_rd(ops[i], adr[i])) begin
                mismatched++;
                $display("FAIL byte_merge[%0d]: RD=%h want %h", i, RD, want[i]);
            end
        end
    endtask

    task automatic test_half_sign();
        logic [31:0] want [3];
        logic [2:0]  ops [3];
        logic [31:0] adr [3];
        want = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000};
        ops  = '{3'd1, 3'd2, 3'd0};
        adr  = '{32'h22, 32'h22, 32'h20};
        do_store(3'd1, 32'h22, 32'h0000_8001);
        for (int i = 0; i < 3; i++) begin
            do_load(ops[i], adr[i]);
            compared++;
            if (RD !== want[i]) begin
                mismatched++;
                $display("FAIL half_sign[%0d]: RD=%h want %h", i, RD, want[i]);
            end
        end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        drive(1'b1, 3'd0, 32'h31, 32'h5555_AAAA);
        #1;
        compared++;
        if (AdES !== 1'b1) begin
            mismatched++;
            $display("FAIL misalign_ades: AdES=%b want 1", AdES);
        end
        @(posedge clk);
        #1;
        WE = 1'b0;
        do_load(3'd0, 32'h30);
        compared++;
        if (RD !== 32'h0 || AdEL !== 1'b0) begin
            mismatched++;
            $display("FAIL misalign_nochange: RD=%h AdEL=%b want 0 0", RD, AdEL);
        end
        do_load(3'd1, 32'h33);
        compared++;
        if (AdEL !== 1'b1 || RD !== 32'h0 || AdES !== 1'b0) begin
            mismatched++;
            $display("FAIL misalign_adel: AdEL=%b RD=%h AdES=%b want 1 0 0", AdEL, RD, AdES);
        end
    endtask

    task automatic test_range();
        do_store(3'd0, 32'h2FFC, 32'hCAFE_F00D);
        do_load(3'd0, 32'h2FFC);
        compared++;
        if (RD !== 32'hCAFE_F00D || AdEL !== 1'b0) begin
            mismatched++;
            $display("FAIL range_top: RD=%h AdEL=%b want cafef00d 0", RD, AdEL);
        end
        @(negedge clk);
        drive(1'b1, 3'd0, 32'h3000, 32'h1111_2222);
        #1;
        compared++;
        if (AdES !== 1'b1 || AdEL !== 1'b1 || RD !== 32'h0) begin
            mismatched++;
            $display("FAIL range_over: AdES=%b AdEL=%b RD=%h want 1 1 0", AdES, AdEL, RD);
        end
        @(posedge clk);
        #1;
        WE = 1'b0;
        do_load(3'd0, 32'h0);
        compared++;
        if (RD !== ref_rd(3'd0, 32'h0)) begin
            mismatched++;
            $display("FAIL range_nowrap: RD=%h want %h", RD, ref_rd(3'd0, 32'h0));
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 3'd4, 32'h40, 32'h0000_0011);
        @(posedge clk); ref_store(3'd4, 32'h40, 32'h11);
        @(negedge clk);
        drive(1'b1, 3'd3, 32'h41, 32'h0000_0022);
        @(posedge clk); ref_store(3'd3, 32'h41, 32'h22);
        @(negedge clk);
        drive(1'b1, 3'd2, 32'h42, 32'h0000_4433);
        #1;
        compared++;
        if (RD !== 32'h0) begin
            mismatched++;
            $display("FAIL b2b_nobypass: RD=%h want 0", RD);
        end
        @(posedge clk); ref_store(3'd2, 32'h42, 32'h4433);
        #1;
        WE = 1'b0;
        do_load(3'd0, 32'h40);
        compared++;
        if (RD !== 32'h4433_2211) begin
            mismatched++;
            $display("FAIL b2b_accum: RD=%h want 44332211", RD);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [2:0]  op;
        logic        we;
        logic [31:0] d;
        int          sel;
        for (int n = 0; n < 500; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5)       a = BASE + 32'($urandom_range(0, 63));
            else if (sel < 8)  a = BASE + 32'h2FC0 + 32'($urandom_range(0, 79));
            else if (sel < 9)  a = BASE + 32'h3000 + 32'($urandom_range(0, 15));
            else               a = $urandom();
            op = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            d  = $urandom();
            @(negedge clk);
            drive(we, op, a, d);
            #1;
            compared++;
            if (AdEL !== ref_err(op, a) || AdES !== (we & ref_err(op, a))
                || RD !== ref_rd(op, a)) begin
                mismatched++;
                $display("FAIL random[%0d] op=%0d a=%h we=%b: RD=%h AdEL=%b AdES=%b want %h %b %b",
                         n, op, a, we, RD, AdEL, AdES, ref_rd(op, a), ref_err(op, a),
                         we & ref_err(op, a));
            end
            @(posedge clk);
            if (we) ref_store(op, a, d);
        end
        WE = 1'b0;
    endtask

    task automatic test_async_reset();
        do_store(3'd0, 32'h50, 32'h0BAD_F00D);
        do_load(3'd0, 32'h50);
        #2;
        reset = 1'b0;
        ref_clear();
        #1;
        compared++;
        if (RD !== 32'h0) begin
            mismatched++;
            $display("FAIL async_clear: RD=%h want 0", RD);
        end
        drive(1'b0, 3'd0, 32'h2FFC, 32'h0);
        #1;
        compared++;
        if (RD !== 32'h0 || AdEL !== 1'b0) begin
            mismatched++;
            $display("FAIL async_clear_top: RD=%h AdEL=%b want 0 0", RD, AdEL);
        end
        do_store(3'd0, 32'h50, 32'h7777_7777);
        do_load(3'd0, 32'h50);
        compared++;
        if (RD !== 32'h0) begin
            mismatched++;
            $display("FAIL async_store_ignored: RD=%h want 0", RD);
        end
        @(negedge clk);
        reset = 1'b1;
        do_store(3'd0, 32'h50, 32'h600D_CAFE);
        do_load(3'd0, 32'h50);
        compared++;
        if (RD !== 32'h600D_CAFE) begin
            mismatched++;
            $display("FAIL async_release_store: RD=%h want 600dcafe", RD);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'd0, 32'h10, 32'h0);
        ref_clear();
        #3;
        reset = 1'b0;
        test_reset();
        test_word();
        test_byte_merge();
        test_half_sign();
        test_misalign();
        test_range();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
